// File: rtl/can_pkg.sv
// Shared types, CAN CRC-15 constants and the single-bit LFSR step.
// The CRC engine RTL and its reference model both use crc_step().
package can_pkg;

  localparam int CAN_CRC_W = 15;
  localparam logic [CAN_CRC_W-1:0] CAN_CRC_POLY = 15'h4599;

  localparam logic [1:0] ST_ACCUM  = 2'd0;
  localparam logic [1:0] ST_TX_CRC = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;

  typedef enum logic [1:0] {
    ACCUM  = ST_ACCUM,
    TX_CRC = ST_TX_CRC,
    CHECK  = ST_CHECK
  } state_e;

  // Widest CRC the helper supports. Callers zero-extend narrower values into this word.
  localparam int CRC_MAX_W = 32;
  typedef logic [CRC_MAX_W-1:0] crc_word_t;

  // One MSB-first LFSR step on the low w bits of r.
  function automatic crc_word_t crc_step(input crc_word_t r, input logic b,
                                         input crc_word_t poly, input int unsigned w);
    crc_word_t mask;
    logic      fb;
    mask = (w >= CRC_MAX_W) ? '1 : ((crc_word_t'(1) << w) - crc_word_t'(1));
    fb   = b ^ (|(r & (crc_word_t'(1) << (w - 1))));
    return ((r << 1) ^ (fb ? poly : '0)) & mask;
  endfunction

endpackage

// File: rtl/can_crc_lfsr_step.sv
// Combinational DATA_W-deep unrolled LFSR chain.
// data_i[DATA_W-1] is applied first.
module can_crc_lfsr_step
  import can_pkg::*;
#(
  parameter int                CRC_W  = CAN_CRC_W,
  parameter logic [CRC_W-1:0]  POLY   = CAN_CRC_POLY,
  parameter int                DATA_W = 1
) (
  input  logic [CRC_W-1:0]  crc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CRC_W-1:0]  crc_o
);

  logic [CRC_W-1:0] w_chain [DATA_W+1];

  assign w_chain[0] = crc_i;

  for (genvar i = 0; i < DATA_W; i++) begin : g_step
    assign w_chain[i+1] = CRC_W'(crc_step(crc_word_t'(w_chain[i]), data_i[DATA_W-1-i],
                                          crc_word_t'(POLY), CRC_W));
  end

  assign crc_o = w_chain[DATA_W];

endmodule

// File: rtl/can_crc_engine.sv
// Parametrised CAN CRC engine with three modes.
// ACCUM accumulates message bits, TX_CRC serialises the CRC, and CHECK tests a received CRC for zero residue.
module can_crc_engine
  import can_pkg::*;
#(
  parameter int               CRC_W  = CAN_CRC_W,
  parameter logic [CRC_W-1:0] POLY   = CAN_CRC_POLY,
  parameter logic [CRC_W-1:0] INIT   = '0,
  parameter int               DATA_W = 1,
  parameter int               CNT_W  = 8
) (
  input  logic              crc_clk_i,
  input  logic              rst_i,
  input  logic              crc_rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              tx_start_i,
  input  logic              rx_check_i,
  output logic [CRC_W-1:0]  crc_reg_o,
  output logic              crc_bit_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              match_o,
  output logic [CNT_W-1:0]  bit_cnt_o
);

  localparam int K_W = $clog2(CRC_W + 1);

  state_e           r_state;
  logic [CRC_W-1:0] r_crc;
  logic [K_W-1:0]   r_k;
  logic             r_done;
  logic             r_match;
  logic [CNT_W-1:0] r_cnt;

  logic [CRC_W-1:0] w_accum_crc;
  logic [CRC_W-1:0] w_chk_crc;
  logic [CNT_W:0]   w_cnt_sum;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_last;

  can_crc_lfsr_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .DATA_W(DATA_W)
  ) u_step (
    .crc_i (r_crc),
    .data_i(data_i),
    .crc_o (w_accum_crc)
  );

  assign w_chk_crc  = CRC_W'(crc_step(crc_word_t'(r_crc), data_i[DATA_W-1],
                                      crc_word_t'(POLY), CRC_W));
  assign w_cnt_sum  = {1'b0, r_cnt} + (CNT_W+1)'(DATA_W);
  assign w_cnt_next = w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
  assign w_last     = (r_k == K_W'(1));

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge crc_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ACCUM;
      r_crc   <= INIT;
      r_k     <= '0;
      r_done  <= 1'b0;
      r_match <= 1'b0;
      r_cnt   <= '0;
    end else if (crc_rst_i) begin
      r_state <= ACCUM;
      r_crc   <= INIT;
      r_k     <= '0;
      r_done  <= 1'b0;
      r_match <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ACCUM: begin
          if (en_i) begin
            r_crc <= w_accum_crc;
            r_cnt <= w_cnt_next;
          end
          if (tx_start_i || rx_check_i) begin
            r_state <= tx_start_i ? TX_CRC : CHECK;
            r_k     <= K_W'(CRC_W);
            r_match <= 1'b0;
          end
        end
        TX_CRC: begin
          if (en_i) begin
            if (w_last) begin
              r_state <= ACCUM;
              r_crc   <= INIT;
              r_cnt   <= '0;
              r_done  <= 1'b1;
            end else begin
              r_crc <= {r_crc[CRC_W-2:0], 1'b0};
            end
            r_k <= r_k - K_W'(1);
          end
        end
        CHECK: begin
          if (en_i) begin
            if (w_last) begin
              r_state <= ACCUM;
              r_crc   <= INIT;
              r_cnt   <= '0;
              r_done  <= 1'b1;
              r_match <= (w_chk_crc == '0);
            end else begin
              r_crc <= w_chk_crc;
            end
            r_k <= r_k - K_W'(1);
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign crc_reg_o = r_crc;
  assign crc_bit_o = (r_state == TX_CRC) & r_crc[CRC_W-1];
  assign busy_o    = (r_state != ACCUM);
  assign done_o    = r_done;
  assign match_o   = r_match;
  assign bit_cnt_o = r_cnt;

endmodule
